wave_pattern_gen: RTL
=====================

# wave_pattern_gen

Multi-channel, parametrised waveform stimulus generator for the waveform-sample environment. Each burst drives CHANNELS lanes of WIDTH-bit samples in a run-time-selected pattern mode: up count, down count, LFSR random, walking-one or optional deterministic X/Z injection. A start/stop/pause handshake and a programmable burst length give repeatable, cycle-exact waveforms for dump and viewer regression, replacing free-running per-signal random drivers.

## Interface
- WIDTH, 32, sample width per channel, legal 1..32
- CHANNELS, 4, number of output lanes, legal 1..16
- SEED, 32'hACE1_2468, base LFSR seed
- XZ_PERIOD, 8, X/Z injection period in samples, legal 2..255

- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  burst start request, single-cycle pulse
- stop  in  1  abort the current burst
- pause  in  1  level; hold the generator while high
- mode  in  3  pattern mode, latched at accepted start
- burst_len  in  16  samples per burst; 0 = free-running
- data  out  CHANNELS*WIDTH  lane i on bits [i*WIDTH +: WIDTH]
- valid  out  1  data holds a new sample this cycle
- busy  out  1  burst in progress (RUN or HOLD)
- done  out  1  one-cycle pulse on normal burst completion

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: start=1 -> latch mode and burst_len, load per-lane seed values, go to RUN.
- RUN: each cycle emit one sample per lane, valid=1, increment sample_cnt (16-bit).
- RUN + pause=1 -> HOLD. HOLD: data held, valid=0, no advance; pause=0 -> RUN.
- stop=1 in RUN or HOLD -> IDLE next cycle, valid=0, done not pulsed, data held.
- burst_len!=0: the sample with sample_cnt==burst_len-1 is the last; next cycle IDLE, done=1, valid=0.
- burst_len==0: runs until stop; sample_cnt wraps 16'hFFFF -> 0 without effect.
- Mode 0 COUNT_UP: lane i starts at i, +1 per sample, wraps modulo 2^WIDTH.
- Mode 1 COUNT_DOWN: lane i starts at all-ones minus i, -1 per sample, wraps.
- Mode 2 LFSR: per-lane 32-bit Galois LFSR, taps 32'h8020_0003, shift right. Seed is SEED ^ (i * 32'h9E37_79B9). A seed of zero is replaced by 32'h1. Output is the low WIDTH bits of the state after each step.
- Mode 3 WALK_ONE: lane i starts one-hot at bit (i mod WIDTH), rotates left 1 per sample.
- Mode 4 XZ (macro only): LFSR as mode 2. On samples where sample_cnt mod XZ_PERIOD == XZ_PERIOD-1, even lanes output all-z and odd lanes all-x. The LFSR still advances on those samples.
- Modes 5-7, and mode 4 without the macro: treated as mode 2.
- mode/burst_len changes while busy are ignored. start while busy is ignored.
- start, stop and pause in the same cycle: stop wins, then start (IDLE only), then pause.
- start with pause=1 from IDLE: enter HOLD directly. The first sample emits after pause drops.

## Timing
- Reset values: data all 0, valid 0, busy 0, done 0, state IDLE, sample_cnt 0, LFSRs at seed.
- Start latency: start at cycle N -> first valid sample at cycle N+1, busy=1 from N+1.
- Throughput: one sample per cycle per lane in RUN.
- Burst of L samples: valid at N+1..N+L; done=1 and busy=0 at N+L+1.
- Next start is accepted in the same cycle done=1.
- reset mid-burst: all outputs return to reset values the following cycle; no done.
- pause has one-cycle latency: pause high at cycle M -> valid=0 at M+1.

## Configuration
- WAVE_PATTERN_XZ_EN defined: mode 4 X/Z injection is compiled in. Outputs are 4-state and simulation-only.
- WAVE_PATTERN_XZ_EN undefined: no X/Z can be produced, the block is synthesizable, and mode 4 behaves as mode 2.

## Test plan
- CHANNELS=2, WIDTH=8, mode 0, burst_len=4, start -> lane0 0,1,2,3; lane1 1,2,3,4. done pulses one cycle after the 4th sample, then busy=0.
- WIDTH=4, mode 1, burst_len=18 -> lane0 F,E,...,0,F,E (wraps). Followed by an immediate restart in the done cycle, which is accepted.
- Mode 2, burst_len=0, run 1000 cycles, stop -> no lane repeats a zero state; samples match the reference LFSR model bit-exact; IDLE next cycle with no done.
- Mode 3, WIDTH=8, pause high for 3 cycles mid-burst -> valid=0 for 3 cycles, data held. The walking-one sequence resumes exactly where it stopped, and the total number of valid samples equals burst_len.
- With WAVE_PATTERN_XZ_EN, mode 4, XZ_PERIOD=4, burst_len=8 -> samples 3 and 7: lane0 all-z, lane1 all-x. All other samples equal the mode-2 values.
- Reset asserted during RUN at sample 5 of 10 -> next cycle data=0, valid=0, busy=0, no done. A new start produces a sequence identical to a fresh burst.

Source files
------------

// File: rtl/wave_pattern_gen.sv
// wave_pattern_gen
//   Multi-lane waveform stimulus generator. A burst drives CHANNELS lanes of
//   WIDTH-bit samples in a pattern mode chosen at start: up count, down count,
//   Galois LFSR, walking one, or (with WAVE_PATTERN_XZ_EN) LFSR with periodic
//   X/Z injection. Bursts are started, paused and aborted by a small handshake
//   and are either burst_len samples long or free-running (burst_len == 0).
//
//   Optional feature macro: WAVE_PATTERN_XZ_EN (compiles in mode 4 X/Z output;
//   without it mode 4 is an LFSR mode and no X/Z can be produced).
//
// Ports
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   start      in   burst start request (accepted in IDLE only)
//   stop       in   abort current burst, no done pulse
//   pause      in   level, holds the generator while high
//   mode       in   pattern mode, latched at accepted start
//   burst_len  in   samples per burst, 0 = free-running
//   data       out  lane i on bits [i*WIDTH +: WIDTH]
//   valid      out  data carries a new sample this cycle
//   busy       out  burst in progress (RUN or HOLD)
//   done       out  one-cycle pulse on normal burst completion

module wave_pattern_gen #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter logic [31:0] SEED      = 32'hACE1_2468,
  parameter int unsigned XZ_PERIOD = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic [2:0]                mode,
  input  logic [15:0]               burst_len,
  output logic [CHANNELS*WIDTH-1:0] data,
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned DW     = CHANNELS * WIDTH;
  localparam logic [31:0] MASK   = 32'hFFFF_FFFF >> (32 - WIDTH);
  localparam logic [31:0] TAPS   = 32'h8020_0003;
  localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

  localparam logic [2:0] M_UP   = 3'd0;
  localparam logic [2:0] M_DOWN = 3'd1;
  localparam logic [2:0] M_LFSR = 3'd2;
  localparam logic [2:0] M_WALK = 3'd3;
`ifdef WAVE_PATTERN_XZ_EN
  localparam logic [2:0] M_XZ   = 3'd4;
`endif

  // Elaboration-time parameter range check.
  if (WIDTH < 1 || WIDTH > 32 || CHANNELS < 1 || CHANNELS > 16 ||
      XZ_PERIOD < 2 || XZ_PERIOD > 255) begin : g_param_check
    $error("wave_pattern_gen: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   cnt_q, cnt_d;     // index of the next sample to emit
  logic [31:0]   gen_q  [CHANNELS];
  logic [31:0]   gen_d  [CHANNELS];
  logic [31:0]   base   [CHANNELS];
  logic [31:0]   nxt    [CHANNELS];
  logic [DW-1:0] data_d;
  logic          valid_d, busy_d, done_d;
  logic          emit, load;
  logic [2:0]    mode_eff;
  logic [15:0]   emit_idx;
`ifdef WAVE_PATTERN_XZ_EN
  logic          xz_slot;
`endif

  // Per-lane LFSR seed; an all-zero seed would lock the LFSR, so it becomes 1.
  function automatic logic [31:0] lane_seed(input int unsigned i);
    logic [31:0] s;
    s = SEED ^ (32'(i) * GOLDEN);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // Unsupported modes collapse onto the LFSR mode.
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    logic [2:0] r;
    case (m)
      M_UP, M_DOWN, M_WALK: r = m;
`ifdef WAVE_PATTERN_XZ_EN
      M_XZ:                 r = m;
`endif
      default:              r = M_LFSR;
    endcase
    return r;
  endfunction

  // Generator state one step before lane i's first sample, so that every
  // emitted sample is simply step(previous state).
  function automatic logic [31:0] init_val(input logic [2:0] m, input int unsigned i);
    logic [31:0] v;
    case (m)
      M_UP:    v = (32'(i) - 32'd1) & MASK;
      M_DOWN:  v = (32'd0 - 32'(i)) & MASK;
      M_WALK:  v = 32'd1 << (((i % WIDTH) + WIDTH - 1) % WIDTH);
      default: v = lane_seed(i);
    endcase
    return v;
  endfunction

  // One sample advance of the generator state for the given mode.
  function automatic logic [31:0] step(input logic [2:0] m, input logic [31:0] v);
    logic [31:0] r;
    case (m)
      M_UP:    r = (v + 32'd1) & MASK;
      M_DOWN:  r = (v - 32'd1) & MASK;
      M_WALK:  r = ((v << 1) | (v >> (WIDTH - 1))) & MASK;
      default: r = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endcase
    return r;
  endfunction

  // Next-state, generator and output logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data;
    valid_d = 1'b0;
    done_d  = 1'b0;
    emit    = 1'b0;
    load    = 1'b0;

    // In IDLE the candidate burst is described by the live inputs.
    mode_eff = (state_q == IDLE) ? norm_mode(mode) : mode_q;
    emit_idx = (state_q == IDLE) ? 16'd0 : cnt_q;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      base[i]  = (state_q == IDLE) ? init_val(mode_eff, i) : gen_q[i];
      nxt[i]   = step(mode_eff, base[i]);
      gen_d[i] = gen_q[i];
    end

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          mode_d = mode_eff;
          len_d  = burst_len;
          cnt_d  = 16'd0;
          if (pause) begin
            state_d = HOLD;
            load    = 1'b1;
          end else begin
            state_d = RUN;
            emit    = 1'b1;
          end
        end
      end
      RUN: begin
        // Completion beats pause: the last sample is already on the bus.
        if (stop) begin
          state_d = IDLE;
        end else if (len_q != 16'd0 && cnt_q == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (pause) begin
          state_d = HOLD;
        end else begin
          emit = 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
          emit    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef WAVE_PATTERN_XZ_EN
    xz_slot = (mode_eff == M_XZ) &&
              ((32'(emit_idx) % XZ_PERIOD) == (XZ_PERIOD - 1));
`endif

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (load) begin
        gen_d[i] = base[i];
      end
      if (emit) begin
        gen_d[i] = nxt[i];
        data_d[i*WIDTH +: WIDTH] = nxt[i][WIDTH-1:0];
`ifdef WAVE_PATTERN_XZ_EN
        // LFSR keeps advancing underneath the injected value.
        if (xz_slot) begin
          data_d[i*WIDTH +: WIDTH] = (i % 2 == 0) ? {WIDTH{1'bz}} : {WIDTH{1'bx}};
        end
`endif
      end
    end

    if (emit) begin
      valid_d = 1'b1;
      cnt_d   = emit_idx + 16'd1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= M_UP;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        gen_q[i] <= lane_seed(i);
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data    <= data_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        gen_q[i] <= gen_d[i];
      end
    end
  end

endmodule
